// File: rtl/axis_frame_ctrl.sv
// Frame-level control for the histogram stream: SOF sync, EOL checking,
// zero-latency passthrough and CDF handoff sequencing.
module axis_frame_ctrl #(
  parameter int N      = 8,
  parameter int WIDTH  = 355,
  parameter int HEIGHT = 355
) (
  input  logic          i_sys_clk,
  input  logic          i_sys_aresetn,
  input  logic [N-1:0]  s_axis_tdata,
  input  logic          s_axis_tvalid,
  input  logic          s_axis_tlast,
  input  logic          s_axis_tuser,
  output logic          s_axis_tready,
  output logic [N-1:0]  m_axis_tdata,
  output logic          m_axis_tvalid,
  output logic          m_axis_tlast,
  output logic          m_axis_tuser,
  input  logic          m_axis_tready,
  input  logic          i_enable,
  input  logic          i_single_shot,
  input  logic          i_cdf_done,
  input  logic          i_err_clr,
  output logic          o_hist_clr,
  output logic          o_frame_done,
  output logic          o_cdf_start,
  output logic          o_busy,
  output logic          o_err_sof,
  output logic          o_err_eol,
  output logic [10:0]   o_pixel_cnt,
  output logic [10:0]   o_line_cnt
);

  typedef enum logic [2:0] {
    IDLE, WAIT_SOF, STREAM, FLUSH, CDF
  } state_t;

  state_t state, state_nx;
  logic   pass_hs, last_px, last_ln;
  logic   set_sof, set_eol, frame_end;
  logic   enter_ws, enter_cdf;

  assign m_axis_tdata = s_axis_tdata;
  assign m_axis_tlast = s_axis_tlast;
  assign m_axis_tuser = s_axis_tuser;

  assign last_px   = o_pixel_cnt == 11'(WIDTH - 1);
  assign last_ln   = o_line_cnt == 11'(HEIGHT - 1);
  assign enter_ws  = state_nx == WAIT_SOF &&
                     state != WAIT_SOF;
  assign enter_cdf = state_nx == CDF && state != CDF;
  assign o_busy    = state != IDLE;

  always_comb begin
    state_nx      = state;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    pass_hs       = 1'b0;
    set_sof       = 1'b0;
    set_eol       = 1'b0;
    frame_end     = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_enable) state_nx = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (!i_enable) begin
          state_nx = IDLE;
        end else if (s_axis_tvalid && s_axis_tuser) begin
          m_axis_tvalid = 1'b1;
          s_axis_tready = m_axis_tready;
          pass_hs       = m_axis_tready;
        end else begin
          s_axis_tready = 1'b1;
        end
      end
      STREAM: begin
        // A new SOF is left on the bus so WAIT_SOF can take it as pixel 0
        if (s_axis_tvalid && s_axis_tuser) begin
          set_sof  = 1'b1;
          state_nx = WAIT_SOF;
        end else begin
          m_axis_tvalid = s_axis_tvalid;
          s_axis_tready = m_axis_tready;
          pass_hs       = s_axis_tvalid && m_axis_tready;
        end
      end
      FLUSH: begin
        if (!i_enable) begin
          state_nx = IDLE;
        end else begin
          s_axis_tready = !s_axis_tuser;
          if (s_axis_tvalid && s_axis_tuser)
            state_nx = WAIT_SOF;
        end
      end
      CDF: begin
        if (i_cdf_done)
          state_nx = (i_enable && !i_single_shot) ?
                     WAIT_SOF : IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (pass_hs) begin
      if (s_axis_tlast != last_px) begin
        set_eol  = 1'b1;
        state_nx = FLUSH;
      end else if (last_px && last_ln) begin
        frame_end = 1'b1;
        state_nx  = CDF;
      end else begin
        state_nx = STREAM;
      end
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      state        <= IDLE;
      o_hist_clr   <= 1'b0;
      o_frame_done <= 1'b0;
      o_cdf_start  <= 1'b0;
      o_err_sof    <= 1'b0;
      o_err_eol    <= 1'b0;
      o_pixel_cnt  <= '0;
      o_line_cnt   <= '0;
    end else begin
      state        <= state_nx;
      o_hist_clr   <= enter_ws;
      o_frame_done <= frame_end;
      o_cdf_start  <= enter_cdf;
      o_err_sof    <= set_sof | (o_err_sof & ~i_err_clr);
      o_err_eol    <= set_eol | (o_err_eol & ~i_err_clr);
      if (enter_ws) begin
        o_pixel_cnt <= '0;
        o_line_cnt  <= '0;
      end else if (pass_hs) begin
        if (last_px) begin
          o_pixel_cnt <= '0;
          o_line_cnt  <= last_ln ? 11'd0 : o_line_cnt + 11'd1;
        end else begin
          o_pixel_cnt <= o_pixel_cnt + 11'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_frame_ctrl.sv
// Randomized scoreboard bench for axis_frame_ctrl with a frame-position
// reference model (WIDTH=4, HEIGHT=3).
module tb_axis_frame_ctrl;

  localparam int N = 8;
  localparam int W = 4;
  localparam int H = 3;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic [N-1:0]  s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tuser = 1'b0;
  logic          s_tready;
  logic [N-1:0]  m_tdata;
  logic          m_tvalid, m_tlast, m_tuser;
  logic          m_tready = 1'b1;
  logic          en = 1'b0;
  logic          ss = 1'b0;
  logic          cdf_done = 1'b0;
  logic          err_clr = 1'b0;
  logic          hist_clr, frame_done, cdf_start, busy;
  logic          err_sof, err_eol;
  logic [10:0]   pix, lin;

  always #5 clk = ~clk;

  axis_frame_ctrl #(.N(N), .WIDTH(W), .HEIGHT(H)) dut (
    .i_sys_clk     (clk),
    .i_sys_aresetn (rstn),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .m_axis_tready (m_tready),
    .i_enable      (en),
    .i_single_shot (ss),
    .i_cdf_done    (cdf_done),
    .i_err_clr     (err_clr),
    .o_hist_clr    (hist_clr),
    .o_frame_done  (frame_done),
    .o_cdf_start   (cdf_start),
    .o_busy        (busy),
    .o_err_sof     (err_sof),
    .o_err_eol     (err_eol),
    .o_pixel_cnt   (pix),
    .o_line_cnt    (lin)
  );

  typedef struct packed {
    logic [N-1:0] d;
    logic         l;
    logic         u;
  } beat_t;

  typedef enum int {M_WAIT, M_FRAME, M_FLUSH} mmode_t;

  beat_t  exp_q[$];
  int     checks = 0;
  int     fails = 0;
  mmode_t mode = M_WAIT;
  int     pos = 0;
  int     exp_frames = 0;
  int     exp_hist = 0;
  bit     exp_esof = 0;
  bit     exp_eeol = 0;
  bit     cdf_restart = 1;
  int     n_frames = 0;
  int     n_cdf = 0;
  int     n_hist = 0;
  bit     auto_cdf = 1;
  int     mrdy_mode = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Position-in-frame model: which presented beats reach the output,
  // and which errors, frames and histogram clears they cause.
  function automatic void model(input beat_t b);
    if (b.u) begin
      if (mode != M_WAIT) exp_hist++;
      if (mode == M_FRAME) exp_esof = 1;
      mode = M_FRAME;
      pos  = 0;
    end
    if (mode != M_FRAME) return;
    exp_q.push_back(b);
    if (b.l != ((pos % W) == W - 1)) begin
      exp_eeol = 1;
      mode = M_FLUSH;
    end else if (pos == W * H - 1) begin
      exp_frames++;
      if (cdf_restart) exp_hist++;
      mode = M_WAIT;
    end else begin
      pos++;
    end
  endfunction

  task automatic send(input logic [N-1:0] d, input logic l,
                      input logic u);
    int    n;
    beat_t b;
    b.d = d;
    b.l = l;
    b.u = u;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk);
      #1;
    end
    model(b);
    s_tdata  = d;
    s_tlast  = l;
    s_tuser  = u;
    s_tvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept", s_tready, 1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  initial begin
    bit tog;
    tog = 0;
    forever begin
      @(posedge clk);
      #1;
      tog = ~tog;
      case (mrdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = tog;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (hist_clr) n_hist++;
        if (frame_done) n_frames++;
        if (cdf_start) n_cdf++;
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            chk("fwd_unexpected", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            chk("fwd_data", m_tdata, e.d);
            chk("fwd_last", m_tlast, e.l);
            chk("fwd_user", m_tuser, e.u);
            chk("fwd_ready", s_tready, 1);
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (auto_cdf && rstn && cdf_start) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(posedge clk);
        #1;
        cdf_done = 1'b1;
        @(posedge clk);
        #1;
        cdf_done = 1'b0;
      end
    end
  end

  task automatic send_frame(input int kind);
    int   cut;
    logic l;
    cut = $urandom_range(1, W * H - 1);
    for (int p = 0; p < W * H; p++) begin
      if (kind == 5 && p == cut) break;
      l = (p % W) == W - 1;
      if (kind == 4 && p == cut) l = ~l;
      send(N'($urandom), l, p == 0);
    end
  endtask

  task automatic final_checks(input string tag);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk({tag, "_queue"}, exp_q.size(), 0);
    chk({tag, "_frames"}, n_frames, exp_frames);
    chk({tag, "_cdf_start"}, n_cdf, exp_frames);
    chk({tag, "_hist_clr"}, n_hist, exp_hist);
    chk({tag, "_err_sof"}, err_sof, exp_esof);
    chk({tag, "_err_eol"}, err_eol, exp_eeol);
  endtask

  initial begin
    int kind;
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_cnt", {lin, pix}, 0);
    chk("rst_pulses", {hist_clr, frame_done, cdf_start}, 0);
    chk("rst_errs", {err_sof, err_eol}, 0);
    rstn = 1'b1;
    en = 1'b1;
    exp_hist = 1;

    for (int f = 0; f < 14; f++) begin
      mrdy_mode = f % 3;
      kind = (f == 13) ? 0 : $urandom_range(0, 5);
      repeat ($urandom_range(0, 2))
        send(N'($urandom), 1'($urandom_range(0, 1)), 1'b0);
      send_frame(kind);
    end
    final_checks("rand");
    chk("idle_cnt", {lin, pix}, 0);
    chk("idle_busy", busy, 1);
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    @(negedge clk);
    chk("errclr_sof", err_sof, 0);
    chk("errclr_eol", err_eol, 0);
    exp_esof = 0;
    exp_eeol = 0;

    auto_cdf = 0;
    cdf_restart = 0;
    ss = 1'b1;
    mrdy_mode = 1;
    send_frame(0);
    @(negedge clk);
    chk("ss_frame_done", frame_done, 1);
    chk("ss_cdf_start", cdf_start, 1);
    @(posedge clk);
    #1;
    cdf_done = 1'b1;
    s_tdata  = 8'h5a;
    s_tlast  = 1'b0;
    s_tuser  = 1'b1;
    s_tvalid = 1'b1;
    @(posedge clk);
    #1;
    cdf_done = 1'b0;
    en = 1'b0;
    @(negedge clk);
    chk("ss_busy", busy, 0);
    chk("ss_s_tready", s_tready, 0);
    repeat (3) @(negedge clk);
    chk("ss_hold_busy", busy, 0);
    chk("ss_hold_ready", s_tready, 0);
    chk("ss_hold_mvalid", m_tvalid, 0);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;

    ss = 1'b0;
    auto_cdf = 1;
    cdf_restart = 1;
    mrdy_mode = 2;
    en = 1'b1;
    exp_hist++;
    for (int p = 0; p < W + 2; p++)
      send(N'($urandom), (p % W) == W - 1, p == 0);
    @(negedge clk);
    chk("mid_pix", pix, 2);
    chk("mid_line", lin, 1);
    s_tdata  = 8'h11;
    s_tuser  = 1'b1;
    s_tvalid = 1'b1;
    #2 rstn = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_s_tready", s_tready, 0);
    chk("arst_m_tvalid", m_tvalid, 0);
    chk("arst_cnt", {lin, pix}, 0);
    s_tvalid = 1'b0;
    s_tuser  = 1'b0;
    mode = M_WAIT;
    pos  = 0;
    @(posedge clk);
    #3 rstn = 1'b1;
    exp_hist++;
    repeat (2) @(negedge clk);
    chk("post_rst_hist", n_hist, exp_hist);
    chk("post_rst_cnt", {lin, pix}, 0);
    send_frame(0);
    final_checks("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
